// File: rtl/axi2mem_bridge.sv
// axi2mem_bridge: AXI4 slave (32-bit data) that turns AXI read/write bursts
// into sequential single-word req/gnt/rvalid memory accesses, one in flight.
// Ports: clk_i, rst_i (sync, active-high); AXI aw/w/b/ar/r channels;
// memory port mem_req/gnt/addr/we/be/wdata and mem_rvalid/rdata.
module axi2mem_bridge #(
   parameter int AXI4_ADDRESS_WIDTH = 32,
   parameter int AXI4_ID_WIDTH      = 16,
   parameter int AXI4_USER_WIDTH    = 10
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [AXI4_ID_WIDTH-1:0]      aw_id_i,
   input  logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_i,
   input  logic [7:0]                    aw_len_i,
   input  logic [2:0]                    aw_size_i,
   input  logic [1:0]                    aw_burst_i,
   input  logic                          aw_lock_i,
   input  logic [3:0]                    aw_cache_i,
   input  logic [2:0]                    aw_prot_i,
   input  logic [3:0]                    aw_region_i,
   input  logic [3:0]                    aw_qos_i,
   input  logic [AXI4_USER_WIDTH-1:0]    aw_user_i,
   input  logic                          aw_valid_i,
   output logic                          aw_ready_o,
   input  logic [31:0]                   w_data_i,
   input  logic [3:0]                    w_strb_i,
   input  logic                          w_last_i,
   input  logic [AXI4_USER_WIDTH-1:0]    w_user_i,
   input  logic                          w_valid_i,
   output logic                          w_ready_o,
   output logic [AXI4_ID_WIDTH-1:0]      b_id_o,
   output logic [1:0]                    b_resp_o,
   output logic [AXI4_USER_WIDTH-1:0]    b_user_o,
   output logic                          b_valid_o,
   input  logic                          b_ready_i,
   input  logic [AXI4_ID_WIDTH-1:0]      ar_id_i,
   input  logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr_i,
   input  logic [7:0]                    ar_len_i,
   input  logic [2:0]                    ar_size_i,
   input  logic [1:0]                    ar_burst_i,
   input  logic                          ar_lock_i,
   input  logic [3:0]                    ar_cache_i,
   input  logic [2:0]                    ar_prot_i,
   input  logic [3:0]                    ar_region_i,
   input  logic [3:0]                    ar_qos_i,
   input  logic [AXI4_USER_WIDTH-1:0]    ar_user_i,
   input  logic                          ar_valid_i,
   output logic                          ar_ready_o,
   output logic [AXI4_ID_WIDTH-1:0]      r_id_o,
   output logic [31:0]                   r_data_o,
   output logic [1:0]                    r_resp_o,
   output logic                          r_last_o,
   output logic [AXI4_USER_WIDTH-1:0]    r_user_o,
   output logic                          r_valid_o,
   input  logic                          r_ready_i,
   output logic                          mem_req_o,
   input  logic                          mem_gnt_i,
   output logic [AXI4_ADDRESS_WIDTH-1:0] mem_addr_o,
   output logic                          mem_we_o,
   output logic [3:0]                    mem_be_o,
   output logic [31:0]                   mem_wdata_o,
   input  logic                          mem_rvalid_i,
   input  logic [31:0]                   mem_rdata_i
);

   localparam int AW = AXI4_ADDRESS_WIDTH;
   localparam int IW = AXI4_ID_WIDTH;

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT, RD_RESP,
      WR_DATA, WR_REQ, WR_WAIT, WR_RESP
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] id_q, id_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [1:0]    burst_q, burst_d;
   logic          last_wr_q, last_wr_d;
   logic          err_q, err_d;
   logic          werr_q, werr_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    strb_q, strb_d;

   logic          last_beat;
   logic [AW-1:0] next_addr;
   logic          unused_ok;

   assign last_beat = (cnt_q == len_q);
   assign next_addr = (burst_q == 2'b01) ? addr_q + AW'(4) : addr_q;

   // Alternate on a tie: a write wins unless the previous one was a write.
   assign aw_ready_o = (state_q == IDLE) && aw_valid_i
                     && (!ar_valid_i || !last_wr_q);
   assign ar_ready_o = (state_q == IDLE) && ar_valid_i && !aw_ready_o;
   assign w_ready_o  = (state_q == WR_DATA);

   // Error transactions never touch memory.
   assign mem_req_o   = ((state_q == RD_REQ) && !err_q)
                      || (state_q == WR_REQ);
   assign mem_we_o    = (state_q == WR_REQ);
   assign mem_be_o    = (state_q == WR_REQ) ? strb_q : 4'hF;
   assign mem_wdata_o = wdata_q;
   assign mem_addr_o  = {addr_q[AW-1:2], 2'b00};

   assign r_valid_o = (state_q == RD_RESP);
   assign r_data_o  = rdata_q;
   assign r_last_o  = r_valid_o && last_beat;
   assign r_resp_o  = (r_valid_o && err_q) ? 2'b10 : 2'b00;
   assign r_id_o    = id_q;
   assign r_user_o  = '0;

   assign b_valid_o = (state_q == WR_RESP);
   assign b_resp_o  = (b_valid_o && (err_q || werr_q)) ? 2'b10 : 2'b00;
   assign b_id_o    = id_q;
   assign b_user_o  = '0;

   assign unused_ok = ^{aw_lock_i, aw_cache_i, aw_prot_i, aw_region_i,
                        aw_qos_i, aw_user_i, ar_lock_i, ar_cache_i,
                        ar_prot_i, ar_region_i, ar_qos_i, ar_user_i,
                        w_user_i};

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      burst_d   = burst_q;
      last_wr_d = last_wr_q;
      err_d     = err_q;
      werr_d    = werr_q;
      rdata_d   = rdata_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      unique case (state_q)
         IDLE: begin
            if (aw_ready_o) begin
               id_d      = aw_id_i;
               addr_d    = aw_addr_i;
               len_d     = aw_len_i;
               burst_d   = aw_burst_i;
               cnt_d     = 8'd0;
               last_wr_d = 1'b1;
               err_d     = (aw_size_i != 3'b010) || aw_burst_i[1];
               werr_d    = 1'b0;
               state_d   = WR_DATA;
            end else if (ar_ready_o) begin
               id_d      = ar_id_i;
               addr_d    = ar_addr_i;
               len_d     = ar_len_i;
               burst_d   = ar_burst_i;
               cnt_d     = 8'd0;
               last_wr_d = 1'b0;
               err_d     = (ar_size_i != 3'b010) || ar_burst_i[1];
               werr_d    = 1'b0;
               state_d   = RD_REQ;
            end
         end
         RD_REQ: begin
            if (err_q) begin
               rdata_d = '0;
               state_d = RD_RESP;
            end else if (mem_gnt_i) begin
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (mem_rvalid_i) begin
               rdata_d = mem_rdata_i;
               state_d = RD_RESP;
            end
         end
         RD_RESP: begin
            if (r_ready_i) begin
               if (last_beat) begin
                  state_d = IDLE;
               end else begin
                  addr_d  = next_addr;
                  cnt_d   = cnt_q + 8'd1;
                  state_d = RD_REQ;
               end
            end
         end
         WR_DATA: begin
            if (w_valid_i) begin
               wdata_d = w_data_i;
               strb_d  = w_strb_i;
               if (w_last_i != last_beat) werr_d = 1'b1;
               if (!err_q) state_d = WR_REQ;
               else if (last_beat) state_d = WR_RESP;
               else cnt_d = cnt_q + 8'd1;
            end
         end
         WR_REQ: begin
            if (mem_gnt_i) state_d = WR_WAIT;
         end
         WR_WAIT: begin
            if (mem_rvalid_i) begin
               if (last_beat) begin
                  state_d = WR_RESP;
               end else begin
                  addr_d  = next_addr;
                  cnt_d   = cnt_q + 8'd1;
                  state_d = WR_DATA;
               end
            end
         end
         WR_RESP: begin
            if (b_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         burst_q   <= '0;
         last_wr_q <= 1'b0;
         err_q     <= 1'b0;
         werr_q    <= 1'b0;
         rdata_q   <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         burst_q   <= burst_d;
         last_wr_q <= last_wr_d;
         err_q     <= err_d;
         werr_q    <= werr_d;
         rdata_q   <= rdata_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
      end
   end

endmodule

// File: doc/axi2mem_bridge.md
# axi2mem_bridge

AXI4 slave that converts read and write transactions, including bursts, into sequential single-word accesses on a core-style memory port (req/gnt/rvalid). It is the counterpart of the core-to-AXI master bridge. It sits in front of on-chip SRAMs and peripheral register banks so that AXI masters (debug, DMA, cluster) can reach them. The AXI data width is fixed at 32 bits, and the bridge has one memory request in flight at a time.

## Interface
Parameters:
- AXI4_ADDRESS_WIDTH, 32: width of the AXI address and of mem_addr_o.
- AXI4_ID_WIDTH, 16: width of the AXI ID fields.
- AXI4_USER_WIDTH, 10: width of the AXI user fields.

Ports:
- clk_i  in  1  clock; everything is on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- aw_id_i, aw_addr_i, aw_len_i[7:0], aw_size_i[2:0], aw_burst_i[1:0]  in  param  write address channel.
- aw_lock_i, aw_cache_i, aw_prot_i, aw_region_i, aw_qos_i, aw_user_i  in  std  ignored.
- aw_valid_i  in  1, aw_ready_o  out  1: write address handshake.
- w_data_i  in  32, w_strb_i  in  4, w_last_i  in  1, w_user_i  in  param (ignored), w_valid_i  in  1, w_ready_o  out  1: write data channel.
- b_id_o  out  ID, b_resp_o  out  2, b_user_o  out  USER (tied 0), b_valid_o  out  1, b_ready_i  in  1: write response channel.
- ar_* inputs  in  same set as aw_*; ar_valid_i  in  1, ar_ready_o  out  1: read address channel.
- r_id_o  out  ID, r_data_o  out  32, r_resp_o  out  2, r_last_o  out  1, r_user_o  out  USER (tied 0), r_valid_o  out  1, r_ready_i  in  1: read data channel.
- mem_req_o  out  1, mem_gnt_i  in  1: memory request handshake.
- mem_addr_o  out  ADDR, mem_we_o  out  1, mem_be_o  out  4, mem_wdata_o  out  32: memory request payload.
- mem_rvalid_i  in  1, mem_rdata_i  in  32: memory response, one per grant, earliest 1 cycle after the grant.

## Operation
- FSM states:
  - IDLE
  - RD_REQ, RD_WAIT, RD_RESP
  - WR_DATA, WR_REQ, WR_WAIT, WR_RESP
- IDLE:
  - aw_ready_o is asserted when aw_valid_i && (!ar_valid_i || !last_wr).
  - ar_ready_o is asserted when ar_valid_i && !aw_ready_o.
  - Both readys are 0 in every other state.
  - On a handshake, the bridge registers id, addr, len and burst, clears the beat counter, sets last_wr and the error flag, then moves to RD_REQ or WR_DATA.
- Error transaction: the flag is set when size != 3'b010 or burst is not FIXED (00) or INCR (01).
  - No memory accesses are issued for the whole burst.
  - Each read beat returns data 0 with resp SLVERR (10).
  - A write consumes all len+1 W beats and returns B resp SLVERR.
- Read sequence:
  - RD_REQ drives mem_req_o=1, we=0, be=4'hF. On gnt, go to RD_WAIT. In an error transaction, go directly to RD_RESP.
  - RD_WAIT captures mem_rdata_i on mem_rvalid_i and goes to RD_RESP.
  - RD_RESP holds r_valid_o=1 with registered data. r_last_o = (cnt == len). resp is OKAY or SLVERR.
  - On r_ready_i: after the last beat go to IDLE; otherwise advance the address, increment cnt and go to RD_REQ.
- Write sequence:
  - WR_DATA drives w_ready_o=1. On w_valid_i it captures data and strb and goes to WR_REQ (or to the next beat or WR_RESP in an error transaction).
  - WR_REQ drives mem_req_o=1, we=1, be=captured strb. On gnt, go to WR_WAIT.
  - WR_WAIT waits for mem_rvalid_i, then either returns to WR_DATA (advancing the address and cnt) or goes to WR_RESP after beat len.
  - WR_RESP holds b_valid_o=1 until b_ready_i, then goes to IDLE.
- w_last mismatch: w_last_i at a beat other than len, or missing at beat len, sets a sticky error. B resp is then SLVERR, but the memory writes already issued stand.
- Address handling:
  - mem_addr_o = {addr[W-1:2], 2'b00}.
  - INCR adds 4, wrapping modulo 2^W. FIXED keeps the address.
  - 4 KB boundaries are not checked.
- Payload: mem_wdata_o and mem_be_o come from registered W values. r_id_o and b_id_o come from the registered ID.
- mem_rvalid_i is ignored outside RD_WAIT and WR_WAIT.

## Timing
- Reset: state=IDLE, last_wr=0 (so a write wins the first tie), cnt=0, error flags cleared.
  - All valid, ready and req outputs are 0.
  - resp, last and data registers are 0.
- Reset during a transaction abandons it: no R or B beat is produced, and a response from the abandoned access is ignored.
- mem_req_o and its payload stay stable until mem_gnt_i. mem_req_o is never asserted while an access is outstanding.
- r_valid_o/r_data_o/r_last_o/r_resp_o and b_valid_o/b_resp_o stay stable until their ready is seen.
- Minimum latency, with gnt held high and rvalid arriving 1 cycle after gnt:
  - Single read: AR handshake at cycle 0, mem_req_o at cycle 1, rvalid at cycle 2, r_valid_o at cycle 3.
  - Single write: AW at 0, W at 1, req at 2, rvalid at 3, b_valid_o at 4.
- Throughput: the bridge handles one transaction at a time. Each beat costs at least 3 cycles.

## Test plan
- Reset, then AR id=5, addr 0x100, len=0, INCR; memory returns 0xCAFEF00D -> mem_addr_o=0x100, be=F; r_data_o=0xCAFEF00D, r_id_o=5, r_last_o=1, r_resp_o=00; r_valid_o rises at cycle 3.
- AW addr 0x1FC, len=3, INCR, strb 4'b0011 per beat, w_last_i on beat 3 only -> four writes to 0x1FC, 0x200, 0x204, 0x208 with be=0011; one B with resp 00.
- aw_valid_i and ar_valid_i held high together for 4 transactions -> service order is W, R, W, R.
- AR size=3'b011, len=1 -> no mem_req_o; two R beats with data 0, resp 10; r_last_o set on the 2nd beat.
- Write len=1 with w_last_i asserted on beat 0; r_ready_i/b_ready_i and mem_gnt_i stalled randomly -> both memory writes occur, B resp 10, all outputs stable while stalled.
- rst_i pulsed in RD_WAIT, then a stray mem_rvalid_i -> no R beat; outputs at reset values; the next transaction completes normally.
